// File: rtl/noise_cdf_loader.sv
// rtl/noise_cdf_loader.sv - streams a CDF threshold table from ROM into the noise generator
//
// Reads DEPTH entries from a ROM with fixed read latency ROM_LAT and presents each
// one to the noise generator through load_mem/location/mem_data. While streaming,
// it checks that the table is non-decreasing and records the first violation.
//
// Ports:
//   clk        clock
//   rstn       asynchronous active-low reset
//   start      load request, acted on only in IDLE or DONE
//   abort      cancels a load in progress
//   rom_rd_en  ROM read strobe
//   rom_addr   ROM read address
//   rom_data   ROM read data, valid ROM_LAT cycles after rom_rd_en
//   load_mem   an entry is presented this cycle
//   location   table index of the presented entry
//   mem_data   threshold value of the presented entry
//   busy       high in READ and DRAIN
//   done       whole table presented; held until the next start or reset
//   mono_err   sticky: table is not non-decreasing
//   err_index  index of the first entry smaller than its predecessor

module noise_cdf_loader #(
    parameter int DEPTH   = 128,
    parameter int WIDTH   = 64,
    parameter int ROM_LAT = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             abort,
    output logic             rom_rd_en,
    output logic [6:0]       rom_addr,
    input  logic [WIDTH-1:0] rom_data,
    output logic             load_mem,
    output logic [7:0]       location,
    output logic [WIDTH-1:0] mem_data,
    output logic             busy,
    output logic             done,
    output logic             mono_err,
    output logic [7:0]       err_index
);

    localparam logic [6:0] LAST_ADDR = 7'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // One stage per cycle of ROM latency; the last stage lines up with rom_data.
    logic [ROM_LAT-1:0] pipe_vld;
    logic [6:0]         pipe_addr [ROM_LAT];
    logic [WIDTH-1:0]   prev_data;

    logic in_load;
    logic kill;
    logic launch;
    logic ret_vld;
    logic [6:0] ret_addr;
    logic pipe_empty;

    assign in_load    = (state == READ) || (state == DRAIN);
    assign kill       = abort && in_load;
    // abort wins over start when both arrive in IDLE/DONE
    assign launch     = start && !abort && ((state == IDLE) || (state == DONE));
    assign ret_vld    = pipe_vld[ROM_LAT-1] && !kill;
    assign ret_addr   = pipe_addr[ROM_LAT-1];
    // No read being issued and nothing in flight.
    assign pipe_empty = !rom_rd_en && (pipe_vld == '0);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (launch) state_nxt = READ;
            end
            READ: begin
                if (abort)                       state_nxt = IDLE;
                else if (rom_addr == LAST_ADDR)  state_nxt = DRAIN;
            end
            DRAIN: begin
                if (abort)           state_nxt = IDLE;
                else if (pipe_empty) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            rom_rd_en <= 1'b0;
            rom_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            // Status outputs are registered from the next state so they line up
            // with the state they describe.
            rom_rd_en <= (state_nxt == READ);
            busy      <= (state_nxt == READ) || (state_nxt == DRAIN);
            done      <= (state_nxt == DONE);
            if (launch) begin
                rom_addr <= '0;
            end else if ((state == READ) && !abort && (rom_addr != LAST_ADDR)) begin
                rom_addr <= rom_addr + 7'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pipe_vld <= '0;
            for (int i = 0; i < ROM_LAT; i++) pipe_addr[i] <= '0;
        end else if (kill) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0]  <= rom_rd_en;
            pipe_addr[0] <= rom_addr;
            for (int i = 1; i < ROM_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            load_mem  <= 1'b0;
            location  <= '0;
            mem_data  <= '0;
            prev_data <= '0;
            mono_err  <= 1'b0;
            err_index <= '0;
        end else begin
            load_mem <= ret_vld;
            if (ret_vld) begin
                location  <= {1'b0, ret_addr};
                mem_data  <= rom_data;
                prev_data <= rom_data;
            end
            if (launch) begin
                mono_err  <= 1'b0;
                err_index <= '0;
            end else if (ret_vld && (ret_addr != 7'd0) && (rom_data < prev_data) && !mono_err) begin
                // Only the first violation is recorded; the load carries on.
                mono_err  <= 1'b1;
                err_index <= {1'b0, ret_addr};
            end
        end
    end

endmodule

// File: tb/tb_noise_cdf_loader.sv
// tb/tb_noise_cdf_loader.sv - self-checking bench for noise_cdf_loader (ROM_LAT 1 and 2)

module tb_noise_cdf_loader;

    localparam int DEPTH = 128;
    localparam int W     = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn, start, abort;

    logic         rd1, ld1, bsy1, dn1, me1;
    logic [6:0]   ad1;
    logic [7:0]   loc1, ei1;
    logic [W-1:0] md1, rdata1;

    logic         rd2, ld2, bsy2, dn2, me2;
    logic [6:0]   ad2;
    logic [7:0]   loc2, ei2;
    logic [W-1:0] md2, rdata2, rdata2_a;

    logic [W-1:0] rom [DEPTH];

    int n_tests = 0;
    int n_fail  = 0;

    noise_cdf_loader #(.DEPTH(DEPTH), .WIDTH(W), .ROM_LAT(1)) dut1 (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .rom_rd_en(rd1), .rom_addr(ad1), .rom_data(rdata1),
        .load_mem(ld1), .location(loc1), .mem_data(md1),
        .busy(bsy1), .done(dn1), .mono_err(me1), .err_index(ei1)
    );

    noise_cdf_loader #(.DEPTH(DEPTH), .WIDTH(W), .ROM_LAT(2)) dut2 (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .rom_rd_en(rd2), .rom_addr(ad2), .rom_data(rdata2),
        .load_mem(ld2), .location(loc2), .mem_data(md2),
        .busy(bsy2), .done(dn2), .mono_err(me2), .err_index(ei2)
    );

    // ROM models: data appears one or two cycles after the address is presented.
    always @(posedge clk) begin
        rdata1   <= rom[ad1];
        rdata2_a <= rom[ad2];
        rdata2   <= rdata2_a;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int first_bad();
        for (int k = 1; k < DEPTH; k++)
            if (rom[k] < rom[k-1]) return k;
        return -1;
    endfunction

    // Expected behaviour derived from the cycle schedule: start sampled at edge 0.
    task automatic chk_dut(input string p, input int c, input int lat, input int fb, input int abort_at,
                           input logic rd, input logic [6:0] ad, input logic ld, input logic [7:0] loc,
                           input logic [W-1:0] md, input logic bsy, input logic dn, input logic me,
                           input logic [7:0] ei);
        bit    aborted = (abort_at > 0) && (c > abort_at);
        string t = $sformatf("%s c%0d", p, c);
        bit    exp_rd = !aborted && (c >= 1) && (c <= DEPTH);
        bit    exp_me;
        int    k;
        check({t, " rom_rd_en"}, 64'(rd), 64'(exp_rd));
        if (exp_rd) check({t, " rom_addr"}, 64'(ad), 64'(c - 1));
        check({t, " load_mem"}, 64'(ld), 64'(!aborted && (c >= 2 + lat) && (c <= 1 + lat + DEPTH)));
        check({t, " busy"}, 64'(bsy), 64'(!aborted && (c <= 1 + lat + DEPTH)));
        check({t, " done"}, 64'(dn), 64'(!aborted && (c >= 2 + lat + DEPTH)));
        if (!aborted) begin
            if (c >= 2 + lat) begin
                k = c - 2 - lat;
                if (k > DEPTH - 1) k = DEPTH - 1;
                check({t, " location"}, 64'(loc), 64'(k));
                check({t, " mem_data"}, md, rom[k]);
            end
            exp_me = (fb > 0) && (c >= 2 + lat + fb);
            check({t, " mono_err"}, 64'(me), 64'(exp_me));
            check({t, " err_index"}, 64'(ei), exp_me ? 64'(fb) : 64'd0);
        end
    endtask

    task automatic chk_zero(input string p, input logic rd, input logic [6:0] ad, input logic ld,
                            input logic [7:0] loc, input logic [W-1:0] md, input logic bsy,
                            input logic dn, input logic me, input logic [7:0] ei);
        check({p, " rom_rd_en"}, 64'(rd), 64'd0);
        check({p, " rom_addr"}, 64'(ad), 64'd0);
        check({p, " load_mem"}, 64'(ld), 64'd0);
        check({p, " location"}, 64'(loc), 64'd0);
        check({p, " mem_data"}, md, 64'd0);
        check({p, " busy"}, 64'(bsy), 64'd0);
        check({p, " done"}, 64'(dn), 64'd0);
        check({p, " mono_err"}, 64'(me), 64'd0);
        check({p, " err_index"}, 64'(ei), 64'd0);
    endtask

    // Called at a falling edge (cycle 0); returns at the falling edge of cycle last_c+1.
    task automatic run_load(input int abort_at, input int start_at, input int last_c);
        int fb = first_bad();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= last_c; c++) begin
            chk_dut("L1", c, 1, fb, abort_at, rd1, ad1, ld1, loc1, md1, bsy1, dn1, me1, ei1);
            chk_dut("L2", c, 2, fb, abort_at, rd2, ad2, ld2, loc2, md2, bsy2, dn2, me2, ei2);
            start = (c == start_at);
            abort = (c == abort_at);
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic fill_ramp();
        for (int k = 0; k < DEPTH; k++) rom[k] = 64'(k) << 57;
    endtask

    task automatic fill_random();
        logic [W-1:0] v = {$urandom, $urandom} >> 4;
        for (int k = 0; k < DEPTH; k++) begin
            if (k > 0 && $urandom_range(0, 49) == 0) v = v - 64'($urandom_range(1, 1000));
            else if (k > 0) v = v + 64'($urandom_range(0, 2));
            rom[k] = v;
        end
    endtask

    initial begin
        rstn  = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        fill_ramp();
        repeat (2) @(negedge clk);
        chk_zero("init L1", rd1, ad1, ld1, loc1, md1, bsy1, dn1, me1, ei1);
        chk_zero("init L2", rd2, ad2, ld2, loc2, md2, bsy2, dn2, me2, ei2);
        rstn = 1'b1;
        @(negedge clk);

        // Ramp table
        run_load(0, 0, DEPTH + 6);

        // Two violations: only the first is reported
        rom[40] = rom[39] - 64'd1;
        rom[90] = 64'd0;
        run_load(0, 0, DEPTH + 6);

        // start together with abort in DONE is ignored
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("done kept L1", 64'(dn1), 64'd1);
        check("done kept L2", 64'(dn2), 64'd1);
        check("busy idle L1", 64'(bsy1), 64'd0);

        // Fresh load from DONE with mono_err set clears error flags
        fill_ramp();
        run_load(50, 30, 60);

        // start together with abort in IDLE is ignored
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("idle hold busy L1", 64'(bsy1), 64'd0);
        check("idle hold rd L2", 64'(rd2), 64'd0);
        run_load(0, 0, DEPTH + 6);

        // Randomized tables with equal runs and occasional drops
        for (int r = 0; r < 3; r++) begin
            fill_random();
            run_load(0, 0, DEPTH + 6);
        end

        // Reset in the middle of a load
        rom[100] = rom[99] - 64'd5;
        run_load(0, 0, 69);
        rstn = 1'b0;
        #1;
        chk_zero("rst L1", rd1, ad1, ld1, loc1, md1, bsy1, dn1, me1, ei1);
        chk_zero("rst L2", rd2, ad2, ld2, loc2, md2, bsy2, dn2, me2, ei2);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        check("post rst busy L1", 64'(bsy1), 64'd0);
        check("post rst rd L2", 64'(rd2), 64'd0);
        fill_random();
        run_load(0, 0, DEPTH + 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
